// File: rtl/level_guess_core_pkg.sv
// Shared types and helpers for the guessing-level engine: FSM states,
// width helpers and the default screen geometry.
package level_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        EVAL  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    localparam int Y_BASE  = 32;
    localparam int SLOT_H  = 28;
    localparam int X_LIMIT = 500;

    function automatic int slot_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int guess_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/level_guess_core_if.sv
// Handshake/status bundle between the game FSM and the level engine.
// repeat_guess exists only when REPEAT_FILTER_EN is defined.
interface level_guess_core_if #(
    parameter int SW = 4,
    parameter int GW = 3
);
    logic          level_start;
    logic [SW-1:0] target;
    logic [9:0]    pickY;
    logic [9:0]    pickLRx;
    logic          guess_btn;
    logic [SW-1:0] sel_slot;
    logic          sel_valid;
    logic          level_done;
    logic          level_fail;
    logic          close;
    logic          hint_high;
    logic          hint_low;
    logic [GW-1:0] guesses;
    logic [SW-1:0] target_out;
`ifdef REPEAT_FILTER_EN
    logic          repeat_guess;
`endif

    modport master (
        output level_start, target, pickY, pickLRx, guess_btn,
        input  sel_slot, sel_valid, level_done, level_fail, close,
               hint_high, hint_low, guesses, target_out
`ifdef REPEAT_FILTER_EN
        , input repeat_guess
`endif
    );

    modport slave (
        input  level_start, target, pickY, pickLRx, guess_btn,
        output sel_slot, sel_valid, level_done, level_fail, close,
               hint_high, hint_low, guesses, target_out
`ifdef REPEAT_FILTER_EN
        , output repeat_guess
`endif
    );

endinterface

// File: rtl/level_guess_core_slot_decoder.sv
// Registered cursor-Y to slot decode using a compare chain against slot
// boundaries; sel_slot holds its last value while the cursor is off-field.
module level_slot_decoder
    import level_pkg::*;
#(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_H    = level_pkg::SLOT_H,
    parameter int Y_BASE    = level_pkg::Y_BASE,
    parameter int SW        = slot_w(NUM_SLOTS)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [9:0]    pickY,
    output logic [SW-1:0] sel_slot,
    output logic          sel_valid
);

    localparam int Y_END = Y_BASE + NUM_SLOTS * SLOT_H;

    logic [31:0]   y_ext;
    logic [31:0]   y_off;
    logic          in_field;
    logic [SW-1:0] slot_nx;

    always_comb begin
        y_ext    = {22'd0, pickY};
        in_field = (y_ext >= 32'(Y_BASE)) && (y_ext < 32'(Y_END));
        y_off    = y_ext - 32'(Y_BASE);
        slot_nx  = '0;
        // highest boundary crossed wins; boundaries are ascending so no overlap
        for (int i = 1; i < NUM_SLOTS; i++) begin
            if (y_off >= 32'(i * SLOT_H))
                slot_nx = SW'(i);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_slot  <= '0;
            sel_valid <= 1'b0;
        end else begin
            sel_valid <= in_field;
            if (in_field)
                sel_slot <= slot_nx;
        end
    end

endmodule

// File: rtl/level_guess_core.sv
// Guessing-level engine: latches a target, evaluates guesses, reports hints.
// REPEAT_FILTER_EN adds a guessed-slot bitmap and the repeat_guess pulse.
//
// state | meaning
// IDLE  | waiting for level_start rising edge
// ARMED | waiting for an accepted guess press
// EVAL  | one cycle: count guess, update hints, decide outcome
// WIN   | target hit, level_done held
// LOSE  | guess limit reached, level_fail held
module level_guess_core
    import level_pkg::*;
#(
    parameter int NUM_SLOTS   = 16,
    parameter int SLOT_H      = level_pkg::SLOT_H,
    parameter int Y_BASE      = level_pkg::Y_BASE,
    parameter int X_LIMIT     = level_pkg::X_LIMIT,
    parameter int MAX_GUESSES = 7,
    parameter int CLOSE_DIST  = 1
) (
    input logic          Clk,
    input logic          Reset_n,
    level_guess_core_if.slave bus
);

    localparam int SW = slot_w(NUM_SLOTS);
    localparam int GW = guess_w(MAX_GUESSES);
    localparam logic [GW-1:0] MAX_G = GW'(MAX_GUESSES);

    state_t        state;
    logic          btn_q;
    logic          start_q;
    logic [SW-1:0] tgt;
    logic [SW-1:0] guess_reg;
    logic [GW-1:0] guesses;
    logic          done, fail, close_r, hint_h, hint_l;
    logic [SW-1:0] sel_slot;
    logic          sel_valid;
    logic          guess_ev, x_ok;
    logic [SW:0]   diff;
    logic          near;
`ifdef REPEAT_FILTER_EN
    logic [NUM_SLOTS-1:0] seen;
    logic                 repeat_q;
`endif

    level_slot_decoder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_H    (SLOT_H),
        .Y_BASE    (Y_BASE),
        .SW        (SW)
    ) u_dec (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pickY     (bus.pickY),
        .sel_slot  (sel_slot),
        .sel_valid (sel_valid)
    );

    // one extra bit keeps the difference from wrapping between the end slots
    always_comb begin
        guess_ev = bus.guess_btn & ~btn_q;
        x_ok     = {22'd0, bus.pickLRx} <= 32'(X_LIMIT);
        if (guess_reg > tgt)
            diff = {1'b0, guess_reg} - {1'b0, tgt};
        else
            diff = {1'b0, tgt} - {1'b0, guess_reg};
        near = (diff != '0) && (32'(diff) <= 32'(CLOSE_DIST));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            btn_q     <= 1'b0;
            start_q   <= 1'b0;
            tgt       <= '0;
            guess_reg <= '0;
            guesses   <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
            close_r   <= 1'b0;
            hint_h    <= 1'b0;
            hint_l    <= 1'b0;
`ifdef REPEAT_FILTER_EN
            seen      <= '0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            btn_q   <= bus.guess_btn;
            start_q <= bus.level_start;
`ifdef REPEAT_FILTER_EN
            repeat_q <= 1'b0;
`endif
            if (state != IDLE && !bus.level_start) begin
                state   <= IDLE;
                tgt     <= '0;
                guesses <= '0;
                done    <= 1'b0;
                fail    <= 1'b0;
                close_r <= 1'b0;
                hint_h  <= 1'b0;
                hint_l  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.level_start && !start_q) begin
                            tgt     <= bus.target;
                            guesses <= '0;
                            done    <= 1'b0;
                            fail    <= 1'b0;
                            close_r <= 1'b0;
                            hint_h  <= 1'b0;
                            hint_l  <= 1'b0;
`ifdef REPEAT_FILTER_EN
                            seen    <= '0;
`endif
                            state   <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (guess_ev && sel_valid && x_ok) begin
`ifdef REPEAT_FILTER_EN
                            if (seen[sel_slot]) begin
                                repeat_q <= 1'b1;
                            end else begin
                                seen[sel_slot] <= 1'b1;
                                guess_reg      <= sel_slot;
                                state          <= EVAL;
                            end
`else
                            guess_reg <= sel_slot;
                            state     <= EVAL;
`endif
                        end
                    end
                    EVAL: begin
                        if (guesses != MAX_G)
                            guesses <= guesses + GW'(1);
                        if (guess_reg == tgt) begin
                            close_r <= 1'b0;
                            hint_h  <= 1'b0;
                            hint_l  <= 1'b0;
                            done    <= 1'b1;
                            state   <= WIN;
                        end else begin
                            close_r <= near;
                            hint_h  <= guess_reg < tgt;
                            hint_l  <= guess_reg > tgt;
                            if (guesses + GW'(1) >= MAX_G) begin
                                fail  <= 1'b1;
                                state <= LOSE;
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                    WIN, LOSE: state <= state;
                    default:   state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sel_slot   = sel_slot;
    assign bus.sel_valid  = sel_valid;
    assign bus.level_done = done;
    assign bus.level_fail = fail;
    assign bus.close      = close_r;
    assign bus.hint_high  = hint_h;
    assign bus.hint_low   = hint_l;
    assign bus.guesses    = guesses;
    assign bus.target_out = tgt;
`ifdef REPEAT_FILTER_EN
    assign bus.repeat_guess = repeat_q;
`endif

endmodule

// File: doc/level_guess_core.md
Name: level_guess_core

Overview:
Parametrised next-generation guessing-level engine for the number-picker game. It maps the cursor Y position to one of NUM_SLOTS slots and latches a random target when a level starts. It counts guesses against a limit and reports win/lose plus close/higher/lower hints to the top-level game FSM and the VGA/hex display logic. It replaces the fixed 16-slot, single-mode easy level with a block whose slot count, slot height, guess limit and "close" window are all set by parameters.

Parameters:
NUM_SLOTS, 16, number of selectable slots (2..64)
SLOT_H, 28, slot height in pixels
Y_BASE, 32, first pixel row of slot 0
X_LIMIT, 500, a guess is accepted only if pickLRx <= X_LIMIT
MAX_GUESSES, 7, guesses allowed before loss (1..15)
CLOSE_DIST, 1, |guess - target| <= CLOSE_DIST and nonzero asserts close

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
level_start  in  1  level enable; rising edge starts, low aborts
target  in  SW=$clog2(NUM_SLOTS)  random slot index from the RNG, sampled at start
pickY  in  10  cursor Y
pickLRx  in  10  cursor X
guess_btn  in  1  raw guess button (active-high, already synchronised)
sel_slot  out  SW  currently hovered slot
sel_valid  out  1  pickY lies inside the slot field
level_done  out  1  win, held
level_fail  out  1  guesses exhausted, held
close  out  1  last evaluated guess was within CLOSE_DIST
hint_high  out  1  last guess < target
hint_low  out  1  last guess > target
guesses  out  GW=$clog2(MAX_GUESSES+1)  guesses consumed
target_out  out  SW  latched target, for hex debug display

Behaviour:
- Reset (async, Reset_n=0): state IDLE. All outputs 0. Latched target 0. Button edge register 0.
- Slot decode is registered (1-cycle latency from pickY to sel_slot/sel_valid).
  - sel_valid=1 iff Y_BASE <= pickY < Y_BASE + NUM_SLOTS*SLOT_H.
  - sel_slot = (pickY - Y_BASE)/SLOT_H, built from a comparator/subtract chain, not a divider.
  - Slot boundaries are disjoint; no overlap.
  - When invalid, sel_slot holds its last value.
- Guess event: the cycle in which guess_btn=1 and its previous-cycle value is 0 (one event per press).
- FSM states: IDLE, ARMED, EVAL, WIN, LOSE.
  - IDLE: on a rising edge of level_start, latch target, clear guesses/close/hint_* and go to ARMED.
  - ARMED: a guess event with sel_valid=1 and pickLRx <= X_LIMIT latches sel_slot into guess_reg and goes to EVAL. Events outside these conditions are ignored and do not count.
  - EVAL (exactly one cycle): guesses += 1; update close/hint_high/hint_low from guess_reg vs target. Then:
    - equal -> WIN, with close=hint_*=0;
    - else if the new count == MAX_GUESSES -> LOSE;
    - else -> ARMED.
  - WIN: level_done=1 (held). LOSE: level_fail=1 (held). Hints keep their last values.
- Latency: button edge to level_done is 2 cycles: edge seen in ARMED, EVAL, then WIN registered.
- level_start=0 in any non-IDLE state returns to IDLE next cycle and clears all status outputs (abort). Reset mid-level behaves identically but is immediate.
- Distance arithmetic uses SW+1-bit unsigned absolute difference; no wrap-around. Slot 0 and slot NUM_SLOTS-1 are never close to each other.
- guesses saturates at MAX_GUESSES and never wraps.
- target_out is the latched value, stable for the whole level.

Optional Feature:
REPEAT_FILTER_EN
- Defined: an NUM_SLOTS-bit guessed-slot bitmap is cleared at level start. A guess of an already-guessed slot goes ARMED->ARMED without EVAL, does not increment guesses, and leaves the hints unchanged. An extra output repeat_guess pulses high for 1 cycle.
- Undefined: no bitmap and no repeat_guess port. Every accepted guess is evaluated and counted.

Decomposition:
- Package level_pkg: the FSM state enum (IDLE, ARMED, EVAL, WIN, LOSE), the slot-width and guess-width helper functions, and the default geometry constants (Y_BASE, SLOT_H, X_LIMIT).
- One sub-module, level_slot_decoder (pickY -> registered sel_slot/sel_valid), parametrised by NUM_SLOTS/SLOT_H/Y_BASE.

Test Plan:
All scenarios use default parameters.
- Start with target=5; pickY=180 (slot 5), pickLRx=300; press -> level_done=1 two cycles after the edge, guesses=1, close=0.
- Target=5; guess pickY=150 (slot 4) -> close=1, hint_high=1, hint_low=0, guesses=1, state ARMED. Then guess pickY=250 (slot 7) -> close=0, hint_low=1.
- Target=0; seven guesses at slot 9 -> guesses reaches 7, level_fail=1, and an eighth press is ignored (guesses stays 7).
- Press with pickLRx=520, or with pickY=20 -> no change to guesses or state. Holding guess_btn high for 50 cycles counts as exactly one guess.
- Deassert level_start mid-level after 3 guesses -> IDLE next cycle, all outputs 0. Re-start with target=12 -> target_out=12, guesses=0. Assert Reset_n=0 asynchronously mid-EVAL -> outputs 0 without waiting for a clock edge.
- With REPEAT_FILTER_EN defined: guess slot 3 twice -> guesses=1, repeat_guess pulses once. Boundary check: pickY=59 gives slot 0 and pickY=60 gives slot 1.
